// File: rtl/vpu_sram_responder_if.sv
// vpu_sram_responder_if: operand-fetch / write-back bus between the VPU (master)
// and the banked scratchpad (slave). Three source read ports, one dest write port.
interface vpu_sram_responder_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 256
);
   logic [2:0]                 rd_req_i;
   logic [2:0][ADDR_WIDTH-1:0] rd_addr_i;
   logic [2:0]                 rd_gnt_o;
   logic [2:0]                 rd_rvalid_o;
   logic [2:0][DATA_WIDTH-1:0] rd_rdata_o;
   logic                       wr_req_i;
   logic [ADDR_WIDTH-1:0]      wr_addr_i;
   logic [DATA_WIDTH-1:0]      wr_data_i;
   logic                       wr_gnt_o;

   modport master (
      output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
      input  rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o
   );

   modport slave (
      input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
      output rd_gnt_o, rd_rvalid_o, rd_rdata_o, wr_gnt_o
   );
endinterface

// File: rtl/vpu_sram_responder.sv
// vpu_sram_responder: banked scratchpad answering three VPU read ports and one
// write port. Each single-port bank grants the write if present, otherwise one
// read chosen round-robin. Read data returns exactly RD_LATENCY cycles after grant.
// Optional macro VPU_SRAM_STALL_CNT_EN adds saturating per-port stall counters.

// One single-port bank with its own round-robin pointer over the three read ports.
module vpu_sram_bank #(
   parameter int ROW_W      = 8,
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            rd_hit,
   input  logic [2:0][ROW_W-1:0] rd_row,
   input  logic                  wr_hit,
   input  logic [ROW_W-1:0]      wr_row,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [2:0]            rd_gnt,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [2**ROW_W];
   logic [1:0]            ptr, ptr_nxt;
   logic [ROW_W-1:0]      row_sel;

   // (p + i) mod 3 for p in 0..2, i in 0..2
   function automatic logic [1:0] rr_idx(input logic [1:0] p, input int unsigned i);
      logic [2:0] s;
      s = {1'b0, p} + 3'(i);
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   // Pick the first requesting port from the pointer on; a write blocks all reads.
   always_comb begin
      rd_gnt  = '0;
      ptr_nxt = ptr;
      row_sel = rd_row[0];
      if (!wr_hit) begin
         for (int i = 0; i < 3; i++) begin
            if (rd_gnt == '0 && rd_hit[rr_idx(ptr, i)]) begin
               rd_gnt[rr_idx(ptr, i)] = 1'b1;
               row_sel = rd_row[rr_idx(ptr, i)];
               ptr_nxt = (rr_idx(ptr, i) == 2'd2) ? 2'd0 : rr_idx(ptr, i) + 2'd1;
            end
         end
      end
   end

   // Pointer advances past the granted port only when a read is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= 2'd0;
      else        ptr <= ptr_nxt;
   end

   // Array is deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_hit)       mem[wr_row] <= wr_data;
      else if (|rd_gnt) rdata <= mem[row_sel];
   end
endmodule

module vpu_sram_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 256,
   parameter int NUM_BANKS  = 4,
   parameter int RD_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   vpu_sram_responder_if.slave  bus,
   input  logic                 clr_cnt_i,
   output logic [2:0][31:0]     stall_cnt_o
);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = ADDR_WIDTH - BANK_W;

   logic [NUM_BANKS-1:0][2:0]            bank_gnt;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
   logic [2:0][ROW_W-1:0]                rd_row;
   logic [2:0]                           rd_gnt;

   for (genvar p = 0; p < 3; p++) begin : g_row
      assign rd_row[p] = bus.rd_addr_i[p][ADDR_WIDTH-1:BANK_W];
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [2:0] hit;
      for (genvar p = 0; p < 3; p++) begin : g_hit
         assign hit[p] = bus.rd_req_i[p] && (bus.rd_addr_i[p][BANK_W-1:0] == BANK_W'(b));
      end
      vpu_sram_bank #(.ROW_W(ROW_W), .DATA_WIDTH(DATA_WIDTH)) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .rd_hit  (hit),
         .rd_row  (rd_row),
         .wr_hit  (bus.wr_req_i && (bus.wr_addr_i[BANK_W-1:0] == BANK_W'(b))),
         .wr_row  (bus.wr_addr_i[ADDR_WIDTH-1:BANK_W]),
         .wr_data (bus.wr_data_i),
         .rd_gnt  (bank_gnt[b]),
         .rdata   (bank_rdata[b])
      );
   end

   // Each port targets exactly one bank, so OR-ing bank grants is exact.
   always_comb begin
      rd_gnt = '0;
      for (int b = 0; b < NUM_BANKS; b++) rd_gnt |= bank_gnt[b];
   end

   assign bus.rd_gnt_o = rd_gnt;
   assign bus.wr_gnt_o = bus.wr_req_i;

   for (genvar p = 0; p < 3; p++) begin : g_port
      logic [BANK_W-1:0]     bank_sel_q;
      logic [RD_LATENCY:1]   vld_q;
      logic [RD_LATENCY:0]   vld_pipe;
      logic [DATA_WIDTH-1:0] ret_data, hold_q;

      assign vld_pipe = {vld_q, rd_gnt[p]};

      // Valid shift register; reset drops every in-flight read.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q      <= '0;
            bank_sel_q <= '0;
         end else begin
            vld_q      <= vld_pipe[RD_LATENCY-1:0];
            bank_sel_q <= bus.rd_addr_i[p][BANK_W-1:0];
         end
      end

      // Bank register supplies one cycle; remaining latency is data pipeline.
      if (RD_LATENCY == 1) begin : g_lat1
         assign ret_data = bank_rdata[bank_sel_q];
      end else begin : g_latn
         logic [RD_LATENCY-1:1][DATA_WIDTH-1:0] dat_q;
         // Data stages carry no reset; validity comes from vld_pipe.
         always_ff @(posedge clk) begin
            dat_q[1] <= bank_rdata[bank_sel_q];
            for (int k = 2; k < RD_LATENCY; k++) dat_q[k] <= dat_q[k-1];
         end
         assign ret_data = dat_q[RD_LATENCY-1];
      end

      // Keep the last returned word visible between returns.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                  hold_q <= '0;
         else if (vld_pipe[RD_LATENCY]) hold_q <= ret_data;
      end

      assign bus.rd_rvalid_o[p] = vld_pipe[RD_LATENCY];
      assign bus.rd_rdata_o[p]  = vld_pipe[RD_LATENCY] ? ret_data : hold_q;
   end

`ifdef VPU_SRAM_STALL_CNT_EN
   logic [2:0][31:0] stall_q;

   // Saturating stall counters; clear takes priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         stall_q <= '0;
      else if (clr_cnt_i) stall_q <= '0;
      else begin
         for (int p = 0; p < 3; p++)
            if (bus.rd_req_i[p] && !rd_gnt[p] && stall_q[p] != 32'hFFFF_FFFF)
               stall_q[p] <= stall_q[p] + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   logic unused_clr;
   assign unused_clr  = clr_cnt_i;
   assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vpu_sram_responder.sv
// tb_vpu_sram_responder: directed vector table plus hand sequences for reset
// mid-flight and counter clear. Stall expectations collapse to 0 unless
// VPU_SRAM_STALL_CNT_EN is defined.
module tb_vpu_sram_responder;
   localparam int AW = 10, DW = 256, NB = 4, RL = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr_cnt = 1'b0;
   logic [2:0][31:0] stall_cnt;
   int              n_chk = 0, n_err = 0;

   vpu_sram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   vpu_sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .RD_LATENCY(RL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .clr_cnt_i   (clr_cnt),
      .stall_cnt_o (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]         rq;
      logic [2:0][AW-1:0] a;
      logic               wq;
      logic [AW-1:0]      wa;
      logic [7:0]         wb;
      logic [2:0]         eg;
      logic               ewg;
      logic [2:0]         ev;
      logic [2:0]         ck;
      logic [2:0][7:0]    d;
      logic [2:0][31:0]   s;
   } vec_t;

   vec_t tv[$];

   function automatic logic [DW-1:0] rep(input logic [7:0] b);
      return {32{b}};
   endfunction

   function automatic logic [31:0] es(input int v);
`ifdef VPU_SRAM_STALL_CNT_EN
      return 32'(v);
`else
      return (v > 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   function automatic vec_t mk(input logic [2:0] rq, input int a0, input int a1, input int a2,
                               input logic wq, input int wa, input logic [7:0] wb,
                               input logic [2:0] eg, input logic ewg, input logic [2:0] ev,
                               input logic [2:0] ck, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input int s0, input int s1, input int s2);
      vec_t v;
      v.rq = rq; v.a[0] = AW'(a0); v.a[1] = AW'(a1); v.a[2] = AW'(a2);
      v.wq = wq; v.wa = AW'(wa); v.wb = wb;
      v.eg = eg; v.ewg = ewg; v.ev = ev; v.ck = ck;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
      v.s[0] = es(s0); v.s[1] = es(s1); v.s[2] = es(s2);
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the edge, check mid-cycle, advance to next cycle.
   task automatic apply(input vec_t v, input string tag);
      bus.rd_req_i  = v.rq;
      bus.rd_addr_i = v.a;
      bus.wr_req_i  = v.wq;
      bus.wr_addr_i = v.wa;
      bus.wr_data_i = rep(v.wb);
      @(negedge clk);
      chk({tag, ".rd_gnt"}, DW'(bus.rd_gnt_o), DW'(v.eg));
      chk({tag, ".wr_gnt"}, DW'(bus.wr_gnt_o), DW'(v.ewg));
      chk({tag, ".rvalid"}, DW'(bus.rd_rvalid_o), DW'(v.ev));
      for (int p = 0; p < 3; p++) begin
         if (v.ck[p]) chk($sformatf("%s.rdata%0d", tag, p), bus.rd_rdata_o[p], rep(v.d[p]));
         chk($sformatf("%s.stall%0d", tag, p), DW'(stall_cnt[p]), DW'(v.s[p]));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // cycle-by-cycle table: rq a0 a1 a2 | wq wa wb | eg ewg ev ck | d0 d1 d2 | s0 s1 s2
      // write A5 @5, read it back
      tv.push_back(mk(3'b000,0,0,0, 1,5,8'hA5, 3'b000,1,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b001,5,0,0, 0,0,0,     3'b001,0,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b001,3'b001, 8'hA5,0,0, 0,0,0));
      // preload bank0 rows, then three-way bank0 conflict
      tv.push_back(mk(3'b000,0,0,0, 1,0,8'h10, 3'b000,1,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b000,0,0,0, 1,4,8'h14, 3'b000,1,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b000,0,0,0, 1,8,8'h18, 3'b000,1,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b111,0,4,8, 0,0,0,     3'b001,0,3'b000,3'b000, 0,0,0, 0,0,0));
      tv.push_back(mk(3'b110,0,4,8, 0,0,0,     3'b010,0,3'b000,3'b000, 0,0,0, 0,1,1));
      tv.push_back(mk(3'b100,0,4,8, 0,0,0,     3'b100,0,3'b001,3'b001, 8'h10,0,0, 0,1,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b010,3'b010, 0,8'h14,0, 0,1,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b100,3'b100, 0,0,8'h18, 0,1,2));
      // write/read collision on addr 7
      tv.push_back(mk(3'b000,0,0,0, 1,7,8'h11, 3'b000,1,3'b000,3'b000, 0,0,0, 0,1,2));
      tv.push_back(mk(3'b010,0,7,0, 1,7,8'h22, 3'b000,1,3'b000,3'b000, 0,0,0, 0,1,2));
      tv.push_back(mk(3'b010,0,7,0, 0,0,0,     3'b010,0,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b010,3'b010, 0,8'h22,0, 0,2,2));
      // full-throughput cycle: write bank0, reads banks 1..3
      tv.push_back(mk(3'b000,0,0,0, 1,1,8'h41, 3'b000,1,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 1,2,8'h42, 3'b000,1,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 1,3,8'h43, 3'b000,1,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b111,1,2,3, 1,0,8'h33, 3'b111,1,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b111,3'b111, 8'h41,8'h42,8'h43, 0,2,2));
      tv.push_back(mk(3'b001,0,0,0, 0,0,0,     3'b001,0,3'b000,3'b111, 8'h41,8'h42,8'h43, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b001,3'b001, 8'h33,0,0, 0,2,2));
      // same address from all ports, bank1 pointer sits at 1
      tv.push_back(mk(3'b111,5,5,5, 0,0,0,     3'b010,0,3'b000,3'b000, 0,0,0, 0,2,2));
      tv.push_back(mk(3'b101,5,5,5, 0,0,0,     3'b100,0,3'b000,3'b000, 0,0,0, 1,2,3));
      tv.push_back(mk(3'b001,5,5,5, 0,0,0,     3'b001,0,3'b010,3'b010, 0,8'hA5,0, 2,2,3));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b100,3'b100, 0,0,8'hA5, 2,2,3));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b001,3'b001, 8'hA5,0,0, 2,2,3));
      tv.push_back(mk(3'b000,0,0,0, 0,0,0,     3'b000,0,3'b000,3'b111, 8'hA5,8'hA5,8'hA5, 2,2,3));

      // reset state, then idle after release
      bus.rd_req_i = '0; bus.rd_addr_i = '0; bus.wr_req_i = 1'b0;
      bus.wr_addr_i = '0; bus.wr_data_i = '0;
      @(posedge clk); #1;
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000,3'b111, 0,0,0, 0,0,0), "rst");
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++)
         apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000,3'b111, 0,0,0, 0,0,0), $sformatf("idle%0d", i));

      for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

      // port2 read granted, then reset lands on the in-flight read
      apply(mk(3'b100,0,0,5, 0,0,0, 3'b100,0,3'b000,3'b000, 0,0,0, 2,2,3), "mr_gnt");
      rst_n = 1'b0;
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000,3'b111, 0,0,0, 0,0,0), "mr_rst0");
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000,3'b111, 0,0,0, 0,0,0), "mr_rst1");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000,3'b000, 0,0,0, 0,0,0), $sformatf("mr_post%0d", i));
      // pointer back to 0 and array retained
      apply(mk(3'b111,5,5,5, 0,0,0, 3'b001,0,3'b000,3'b000, 0,0,0, 0,0,0), "rr0");
      apply(mk(3'b110,5,5,5, 0,0,0, 3'b010,0,3'b000,3'b000, 0,0,0, 0,1,1), "rr1");
      apply(mk(3'b100,5,5,5, 0,0,0, 3'b100,0,3'b001,3'b001, 8'hA5,0,0, 0,1,2), "rr2");
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b010,3'b010, 0,8'hA5,0, 0,1,2), "rr3");
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b100,3'b100, 0,0,8'hA5, 0,1,2), "rr4");

      // clear beats a same-cycle stall increment
      clr_cnt = 1'b1;
      apply(mk(3'b001,1,0,0, 1,1,8'h55, 3'b000,1,3'b000,3'b000, 0,0,0, 0,1,2), "clr0");
      clr_cnt = 1'b0;
      apply(mk(3'b001,1,0,0, 0,0,0, 3'b001,0,3'b000,3'b000, 0,0,0, 0,0,0), "clr1");
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b000,3'b000, 0,0,0, 0,0,0), "clr2");
      apply(mk(3'b000,0,0,0, 0,0,0, 3'b000,0,3'b001,3'b001, 8'h55,0,0, 0,0,0), "clr3");

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
